// File: rtl/filtrado_tres_bandas_pkg.sv
// Shared constants, default coefficients, FSM states and fixed-point helpers
// for the three-band filter.
package filtrado_tres_bandas_pkg;

  localparam int unsigned W     = 25;  // sample/coefficient width
  localparam int unsigned FRAC  = 12;  // Q12.12
  localparam int unsigned ACC_W = 53;  // accumulator width

  localparam logic signed [ACC_W-1:0] SAT_MAX = 53'sd16777215;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -53'sd16777216;

  // Low band, fc = fs/20
  localparam logic signed [W-1:0] B_B0_DEF = 25'sd82;
  localparam logic signed [W-1:0] B_B1_DEF = 25'sd164;
  localparam logic signed [W-1:0] B_B2_DEF = 25'sd82;
  localparam logic signed [W-1:0] B_A1_DEF = -25'sd6394;
  localparam logic signed [W-1:0] B_A2_DEF = 25'sd2627;
  // Mid band, f0 = fs/8
  localparam logic signed [W-1:0] M_B0_DEF = 25'sd1070;
  localparam logic signed [W-1:0] M_B1_DEF = 25'sd0;
  localparam logic signed [W-1:0] M_B2_DEF = -25'sd1070;
  localparam logic signed [W-1:0] M_A1_DEF = -25'sd4280;
  localparam logic signed [W-1:0] M_A2_DEF = 25'sd1956;
  // High band, fc = fs/4
  localparam logic signed [W-1:0] A_B0_DEF = 25'sd1200;
  localparam logic signed [W-1:0] A_B1_DEF = -25'sd2400;
  localparam logic signed [W-1:0] A_B2_DEF = 25'sd1200;
  localparam logic signed [W-1:0] A_A1_DEF = 25'sd0;
  localparam logic signed [W-1:0] A_A2_DEF = 25'sd703;

  // Index of the last MAC term (a2*y2)
  localparam logic [2:0] LAST_STEP = 3'd4;

  typedef enum logic [1:0] {StIdle, StMac, StUpd, StOut} state_e;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W-1:0] v);
    return {{(ACC_W-W){v[W-1]}}, v};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[W-1:0];
    if (v < SAT_MIN) return SAT_MIN[W-1:0];
    return v[W-1:0];
  endfunction

endpackage

// File: rtl/filtrado_tres_bandas_biquad_mac.sv
// One biquad band: histories, a single multiplier and accumulator stepped one
// term per cycle by the shared step counter, and output saturation.
module filtrado_tres_bandas_biquad_mac
  import filtrado_tres_bandas_pkg::*;
#(
  parameter logic signed [W-1:0] B0 = 25'sd0,
  parameter logic signed [W-1:0] B1 = 25'sd0,
  parameter logic signed [W-1:0] B2 = 25'sd0,
  parameter logic signed [W-1:0] A1 = 25'sd0,
  parameter logic signed [W-1:0] A2 = 25'sd0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,   // new sample captured
  input  logic                mac_i,   // accumulate term step_i
  input  logic                upd_i,   // commit result, shift histories
  input  logic [2:0]          step_i,
  input  logic signed [W-1:0] x0_i,
  output logic signed [W-1:0] yb_o
);

  logic signed [W-1:0]       x1_q, x2_q, y1_q, y2_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]       coef, opnd;
  logic                      sub;
  logic signed [2*W-1:0]     prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   res;

  // Select coefficient/operand for the current term; feedback terms subtract
  always_comb begin
    coef = '0;
    opnd = '0;
    sub  = 1'b0;
    unique case (step_i)
      3'd0: begin coef = B0; opnd = x0_i; end
      3'd1: begin coef = B1; opnd = x1_q; end
      3'd2: begin coef = B2; opnd = x2_q; end
      3'd3: begin coef = A1; opnd = y1_q; sub = 1'b1; end
      3'd4: begin coef = A2; opnd = y2_q; sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = coef * opnd;
  assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
  assign res      = acc_q >>> FRAC;
  assign yb_o     = y1_q;

  // Accumulator next state
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (mac_i) begin
      acc_d = sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  // Accumulator and history registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
    end else begin
      acc_q <= acc_d;
      if (upd_i) begin
        x2_q <= x1_q;
        x1_q <= x0_i;
        y2_q <= y1_q;
        y1_q <= sat(res);
      end
    end
  end

endmodule

// File: rtl/filtrado_tres_bandas.sv
// Three-band IIR filter: captures a sample on rx, runs three biquads in
// parallel over five MAC cycles, then registers the switch-selected sum.
module filtrado_tres_bandas
  import filtrado_tres_bandas_pkg::*;
#(
  parameter logic signed [W-1:0] B_B0 = B_B0_DEF,
  parameter logic signed [W-1:0] B_B1 = B_B1_DEF,
  parameter logic signed [W-1:0] B_B2 = B_B2_DEF,
  parameter logic signed [W-1:0] B_A1 = B_A1_DEF,
  parameter logic signed [W-1:0] B_A2 = B_A2_DEF,
  parameter logic signed [W-1:0] M_B0 = M_B0_DEF,
  parameter logic signed [W-1:0] M_B1 = M_B1_DEF,
  parameter logic signed [W-1:0] M_B2 = M_B2_DEF,
  parameter logic signed [W-1:0] M_A1 = M_A1_DEF,
  parameter logic signed [W-1:0] M_A2 = M_A2_DEF,
  parameter logic signed [W-1:0] A_B0 = A_B0_DEF,
  parameter logic signed [W-1:0] A_B1 = A_B1_DEF,
  parameter logic signed [W-1:0] A_B2 = A_B2_DEF,
  parameter logic signed [W-1:0] A_A1 = A_A1_DEF,
  parameter logic signed [W-1:0] A_A2 = A_A2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic signed [W-1:0] u,
  input  logic                sw_B,
  input  logic                sw_M,
  input  logic                sw_A,
  output logic signed [W-1:0] y
);

  state_e                  state_q;
  logic [2:0]              step_q;
  logic signed [W-1:0]     x0_q, y_q;
  logic                    clr, mac, upd;
  logic signed [W-1:0]     yb_b, yb_m, yb_a;
  logic signed [ACC_W-1:0] sum;

  assign clr = (state_q == StIdle) && rx;
  assign mac = (state_q == StMac);
  assign upd = (state_q == StUpd);
  assign y   = y_q;

  filtrado_tres_bandas_biquad_mac #(
    .B0(B_B0), .B1(B_B1), .B2(B_B2), .A1(B_A1), .A2(B_A2)
  ) u_band_b (
    .clk_i(clk), .rst_ni(rst), .clr_i(clr), .mac_i(mac), .upd_i(upd),
    .step_i(step_q), .x0_i(x0_q), .yb_o(yb_b)
  );

  filtrado_tres_bandas_biquad_mac #(
    .B0(M_B0), .B1(M_B1), .B2(M_B2), .A1(M_A1), .A2(M_A2)
  ) u_band_m (
    .clk_i(clk), .rst_ni(rst), .clr_i(clr), .mac_i(mac), .upd_i(upd),
    .step_i(step_q), .x0_i(x0_q), .yb_o(yb_m)
  );

  filtrado_tres_bandas_biquad_mac #(
    .B0(A_B0), .B1(A_B1), .B2(A_B2), .A1(A_A1), .A2(A_A2)
  ) u_band_a (
    .clk_i(clk), .rst_ni(rst), .clr_i(clr), .mac_i(mac), .upd_i(upd),
    .step_i(step_q), .x0_i(x0_q), .yb_o(yb_a)
  );

  // Switch-masked sum of band outputs, wide enough that it cannot wrap
  always_comb begin
    sum = '0;
    if (sw_B) sum = sum + sext(yb_b);
    if (sw_M) sum = sum + sext(yb_m);
    if (sw_A) sum = sum + sext(yb_a);
  end

  // Sequencer: capture, five MAC steps, band update, output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      x0_q    <= '0;
      y_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          step_q <= '0;
          if (rx) begin
            x0_q    <= u;
            state_q <= StMac;
          end
        end
        StMac: begin
          step_q <= step_q + 3'd1;
          if (step_q == LAST_STEP) state_q <= StUpd;
        end
        StUpd: state_q <= StOut;
        StOut: begin
          y_q     <= sat(sum);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_filtrado_tres_bandas.sv
// Bench for filtrado_tres_bandas: three instances (default coefficients,
// unity pass-through, gain-2 pass-through) share all inputs; a bit-exact
// model predicts every output and a queue carries expectations to E7.
module tb_filtrado_tres_bandas;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rx = 1'b0;
  logic signed [24:0] u = '0;
  logic               sw_b = 1'b0, sw_m = 1'b0, sw_a = 1'b0;
  logic signed [24:0] y_def, y_pt, y_g2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filtrado_tres_bandas u_def (
    .clk(clk), .rst(rst), .rx(rx), .u(u),
    .sw_B(sw_b), .sw_M(sw_m), .sw_A(sw_a), .y(y_def)
  );

  filtrado_tres_bandas #(
    .B_B0(25'sd4096), .B_B1(25'sd0), .B_B2(25'sd0), .B_A1(25'sd0), .B_A2(25'sd0),
    .M_B0(25'sd0), .M_B1(25'sd0), .M_B2(25'sd0), .M_A1(25'sd0), .M_A2(25'sd0),
    .A_B0(25'sd0), .A_B1(25'sd0), .A_B2(25'sd0), .A_A1(25'sd0), .A_A2(25'sd0)
  ) u_pt (
    .clk(clk), .rst(rst), .rx(rx), .u(u),
    .sw_B(sw_b), .sw_M(sw_m), .sw_A(sw_a), .y(y_pt)
  );

  filtrado_tres_bandas #(
    .B_B0(25'sd8192), .B_B1(25'sd0), .B_B2(25'sd0), .B_A1(25'sd0), .B_A2(25'sd0),
    .M_B0(25'sd0), .M_B1(25'sd0), .M_B2(25'sd0), .M_A1(25'sd0), .M_A2(25'sd0),
    .A_B0(25'sd0), .A_B1(25'sd0), .A_B2(25'sd0), .A_A1(25'sd0), .A_A2(25'sd0)
  ) u_g2 (
    .clk(clk), .rst(rst), .rx(rx), .u(u),
    .sw_B(sw_b), .sw_M(sw_m), .sw_A(sw_a), .y(y_g2)
  );

  // Coefficients per [instance][band][b0,b1,b2,a1,a2]
  int cf [3][3][5] = '{
    '{'{82, 164, 82, -6394, 2627}, '{1070, 0, -1070, -4280, 1956},
      '{1200, -2400, 1200, 0, 703}},
    '{'{4096, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}},
    '{'{8192, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}}
  };
  int hx1 [3][3], hx2 [3][3], hy1 [3][3], hy2 [3][3];
  int last_y [3];

  typedef struct {
    string tag;
    int    e [3];
  } exp_t;
  exp_t sbq [$];

  function automatic int sat_m(input longint v);
    if (v > 64'sd16777215) return 16777215;
    if (v < -64'sd16777216) return -16777216;
    return int'(v);
  endfunction

  function automatic int band_step(input int d, input int b, input int x);
    longint acc;
    int     r;
    acc = longint'(cf[d][b][0]) * x + longint'(cf[d][b][1]) * hx1[d][b]
        + longint'(cf[d][b][2]) * hx2[d][b] - longint'(cf[d][b][3]) * hy1[d][b]
        - longint'(cf[d][b][4]) * hy2[d][b];
    r = sat_m(acc >>> 12);
    hx2[d][b] = hx1[d][b];
    hx1[d][b] = x;
    hy2[d][b] = hy1[d][b];
    hy1[d][b] = r;
    return r;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      last_y[d] = 0;
      for (int b = 0; b < 3; b++) begin
        hx1[d][b] = 0; hx2[d][b] = 0; hy1[d][b] = 0; hy2[d][b] = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobed sample; optionally a second strobe at E3 that must be ignored
  task automatic send(input string tag, input int uval, input bit sb, input bit sm,
                      input bit sa, input bit ov, input int ov_val,
                      input bit busy, input int ubusy);
    exp_t t;
    longint s;
    int yb;
    t.tag = tag;
    for (int d = 0; d < 3; d++) begin
      s = 0;
      for (int b = 0; b < 3; b++) begin
        yb = band_step(d, b, uval);
        if ((b == 0 && sb) || (b == 1 && sm) || (b == 2 && sa)) s += yb;
      end
      t.e[d] = sat_m(s);
    end
    if (ov) t.e[0] = ov_val;
    sbq.push_back(t);

    @(negedge clk);
    u = 25'(uval); sw_b = sb; sw_m = sm; sw_a = sa; rx = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    rx = 1'b0;
    if (busy) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      u = 25'(ubusy); rx = 1'b1;
      @(posedge clk);  // E3
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(posedge clk);
    end else begin
      repeat (6) @(posedge clk);
    end
    @(negedge clk);  // after E6: still the previous output
    check({tag, "_hold"}, int'(y_def), last_y[0]);
    @(posedge clk);  // E7
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      t = sbq.pop_front();
      check({t.tag, "_def"}, int'(y_def), t.e[0]);
      check({t.tag, "_pt"},  int'(y_pt),  t.e[1]);
      check({t.tag, "_g2"},  int'(y_g2),  t.e[2]);
      for (int d = 0; d < 3; d++) last_y[d] = t.e[d];
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic signed [24:0] r;
    model_reset();

    // Reset state
    #2;
    check("reset_def", int'(y_def), 0);
    check("reset_pt", int'(y_pt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Low-band impulse on default coefficients
    send("imp0", 4096, 1, 0, 0, 1, 82, 0, 0);
    send("imp1", 0, 1, 0, 0, 1, 292, 0, 0);
    send("imp2", 0, 1, 0, 0, 0, 0, 0, 0);

    // Pass-through and saturation
    send("pass", 12345, 1, 0, 0, 0, 0, 0, 0);
    send("satpos", 16777215, 1, 0, 0, 0, 0, 0, 0);
    check("satpos_g2_max", int'(y_g2), 16777215);
    send("satneg", -16777216, 1, 0, 0, 0, 0, 0, 0);
    check("satneg_g2_min", int'(y_g2), -16777216);

    // Switch masking
    send("sw_none", 5000, 0, 0, 0, 0, 0, 0, 0);
    check("sw_none_zero", int'(y_def), 0);
    send("sw_b", 3000, 1, 0, 0, 0, 0, 0, 0);
    send("sw_m", -2000, 0, 1, 0, 0, 0, 0, 0);
    send("sw_a", 7000, 0, 0, 1, 0, 0, 0, 0);

    // Strobe during MAC must be ignored
    send("busy", 20000, 1, 1, 1, 0, 0, 1, -9999);
    send("after_busy", 1000, 1, 1, 1, 0, 0, 0, 0);

    // Random samples, all bands on
    for (int i = 0; i < 100; i++) begin
      r = 25'($urandom);
      if (i % 2 == 0) r = r >>> 6;
      send("rand", int'(r), 1, 1, 1, 0, 0, 0, 0);
    end

    // Reset mid-MAC clears y at once, then y stays 0 while idle
    @(negedge clk);
    u = 25'sd777; rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midmac_rst_def", int'(y_def), 0);
    check("midmac_rst_pt", int'(y_pt), 0);
    check("midmac_rst_g2", int'(y_g2), 0);
    model_reset();
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(negedge clk);
      check("idle_zero", int'(y_def), 0);
    end

    // Histories must have been cleared by the reset
    send("imp_after_rst", 4096, 1, 0, 0, 1, 82, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
